dds_wave_shaper: RTL and testbench

Downstream stage of the DDS address generator. It converts each 8-bit phase address into an 8-bit offset-binary DAC code.
- Selectable waveforms: sine, square, triangle and sawtooth. Sine uses a quarter-wave table.
- The code is scaled by an 8-bit amplitude word.
- Runs on the system clock clk_DDS, with a per-sample valid strobe supplied by the address-generation side.
- The 3-stage registered pipeline feeds the DAC driver.

---
 rtl/dds_wave_shaper.sv | 182 ++++++++++++++++++
 tb/tb_dds_wave_shaper.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_shaper.sv
// dds_wave_shaper: converts an 8-bit phase address into an 8-bit offset-binary
// DAC code. It supports sine (quarter-wave table), square, triangle and
// sawtooth waveforms, scaled by an 8-bit amplitude word.
// The pipeline has three registered stages, so each sample leaves 3 clk_DDS
// cycles after it is accepted. Wave_Sel and Amp are captured with each sample.
module dds_wave_shaper #(
  parameter logic [7:0] MID_CODE = 8'd128
) (
  input  logic       clk_DDS,
  input  logic       Rst,
  input  logic       Valid_In,
  input  logic [7:0] Addr_In,
  input  logic [1:0] Wave_Sel,
  input  logic [7:0] Amp,
  output logic [7:0] Dac_Out,
  output logic       Valid_Out
);

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  // Quarter-wave sine table: Q[k] = round(127.5*sin(2*pi*(k+0.5)/256)).
  // The half-sample offset makes the four quadrants mirror exactly, with no
  // duplicated codes at the quadrant seams.
  function automatic logic [6:0] sine_quarter(input logic [5:0] k);
    logic [6:0] m;
    case (k)
      6'd0:  m = 7'd2;    6'd1:  m = 7'd5;    6'd2:  m = 7'd8;    6'd3:  m = 7'd11;
      6'd4:  m = 7'd14;   6'd5:  m = 7'd17;   6'd6:  m = 7'd20;   6'd7:  m = 7'd23;
      6'd8:  m = 7'd26;   6'd9:  m = 7'd29;   6'd10: m = 7'd32;   6'd11: m = 7'd36;
      6'd12: m = 7'd39;   6'd13: m = 7'd41;   6'd14: m = 7'd44;   6'd15: m = 7'd47;
      6'd16: m = 7'd50;   6'd17: m = 7'd53;   6'd18: m = 7'd56;   6'd19: m = 7'd59;
      6'd20: m = 7'd61;   6'd21: m = 7'd64;   6'd22: m = 7'd67;   6'd23: m = 7'd70;
      6'd24: m = 7'd72;   6'd25: m = 7'd75;   6'd26: m = 7'd77;   6'd27: m = 7'd80;
      6'd28: m = 7'd82;   6'd29: m = 7'd84;   6'd30: m = 7'd87;   6'd31: m = 7'd89;
      6'd32: m = 7'd91;   6'd33: m = 7'd93;   6'd34: m = 7'd96;   6'd35: m = 7'd98;
      6'd36: m = 7'd100;  6'd37: m = 7'd101;  6'd38: m = 7'd103;  6'd39: m = 7'd105;
      6'd40: m = 7'd107;  6'd41: m = 7'd109;  6'd42: m = 7'd110;  6'd43: m = 7'd112;
      6'd44: m = 7'd113;  6'd45: m = 7'd115;  6'd46: m = 7'd116;  6'd47: m = 7'd117;
      6'd48: m = 7'd118;  6'd49: m = 7'd120;  6'd50: m = 7'd121;  6'd51: m = 7'd122;
      6'd52: m = 7'd122;  6'd53: m = 7'd123;  6'd54: m = 7'd124;  6'd55: m = 7'd125;
      6'd56: m = 7'd125;  6'd57: m = 7'd126;  6'd58: m = 7'd126;  6'd59: m = 7'd127;
      6'd60: m = 7'd127;  6'd61: m = 7'd127;  6'd62: m = 7'd127;  6'd63: m = 7'd127;
      default: m = 7'd0;
    endcase
    return m;
  endfunction

  // Raw 0..255 wave value for one sample. a[7] is the upper quadrant bit
  // (q[1]), which selects the negative half of the sine.
  function automatic logic [7:0] wave_value(input logic [7:0] a,
                                            input wave_e      sel,
                                            input logic [6:0] m);
    logic [7:0] w;
    case (sel)
      WAVE_SINE:   w = a[7] ? (8'd127 - {1'b0, m}) : (8'd128 + {1'b0, m});
      WAVE_SQUARE: w = a[7] ? 8'd0 : 8'd255;
      WAVE_TRI:    w = a[7] ? (8'd255 - {a[6:0], 1'b0}) : {a[6:0], 1'b0};
      default:     w = a;
    endcase
    return w;
  endfunction

  // Amplitude scaling around the mid code. Gain is (amp+1)/256, and the
  // product is floored by an arithmetic shift. |p| <= 128*256, so 16 signed
  // bits hold every product. The result stays in 0..255 by construction, so
  // no clamp is needed.
  function automatic logic [7:0] scale_code(input logic [7:0] w,
                                            input logic [7:0] amp);
    logic signed [8:0]  s;
    logic signed [9:0]  g;
    logic signed [15:0] p;
    s = $signed({1'b0, w}) - $signed({1'b0, MID_CODE});
    g = $signed({2'b00, amp}) + 10'sd1;
    p = $signed({{7{s[8]}}, s}) * $signed({{6{g[9]}}, g});
    return 8'((p >>> 8) + $signed({8'd0, MID_CODE}));
  endfunction

  // Stage 1 registers: captured input sample
  logic       vld_p1_q, vld_p1_d;
  logic [7:0] addr_p1_q, addr_p1_d;
  wave_e      sel_p1_q, sel_p1_d;
  logic [7:0] amp_p1_q, amp_p1_d;

  // Stage 2 registers: raw wave value
  logic       vld_p2_q, vld_p2_d;
  logic [7:0] wave_p2_q, wave_p2_d;
  logic [7:0] amp_p2_q, amp_p2_d;

  // Stage 3 registers: scaled DAC code
  logic       vld_p3_q, vld_p3_d;
  logic [7:0] dac_p3_q, dac_p3_d;

  // Stage 1 lookup index: odd quadrants read the table mirrored
  logic [5:0] k_p1;
  logic [6:0] m_p1;

  // Stage 1 next state: the valid bit always shifts; data loads only on Valid_In
  always_comb begin
    vld_p1_d  = Valid_In;
    addr_p1_d = addr_p1_q;
    sel_p1_d  = sel_p1_q;
    amp_p1_d  = amp_p1_q;
    if (Valid_In) begin
      addr_p1_d = Addr_In;
      sel_p1_d  = wave_e'(Wave_Sel);
      amp_p1_d  = Amp;
    end
  end

  // ---- stage 1 boundary ----
  // Stage 1 state register
  always_ff @(posedge clk_DDS or negedge Rst) begin
    if (!Rst) begin
      vld_p1_q  <= 1'b0;
      addr_p1_q <= 8'd0;
      sel_p1_q  <= WAVE_SINE;
      amp_p1_q  <= 8'd0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      addr_p1_q <= addr_p1_d;
      sel_p1_q  <= sel_p1_d;
      amp_p1_q  <= amp_p1_d;
    end
  end

  // Stage 2 next state: quarter-wave index and waveform selection
  always_comb begin
    k_p1      = addr_p1_q[6] ? ~addr_p1_q[5:0] : addr_p1_q[5:0];
    m_p1      = sine_quarter(k_p1);
    vld_p2_d  = vld_p1_q;
    wave_p2_d = wave_p2_q;
    amp_p2_d  = amp_p2_q;
    if (vld_p1_q) begin
      wave_p2_d = wave_value(addr_p1_q, sel_p1_q, m_p1);
      amp_p2_d  = amp_p1_q;
    end
  end

  // ---- stage 2 boundary ----
  // Stage 2 state register
  always_ff @(posedge clk_DDS or negedge Rst) begin
    if (!Rst) begin
      vld_p2_q  <= 1'b0;
      wave_p2_q <= 8'd0;
      amp_p2_q  <= 8'd0;
    end else begin
      vld_p2_q  <= vld_p2_d;
      wave_p2_q <= wave_p2_d;
      amp_p2_q  <= amp_p2_d;
    end
  end

  // Stage 3 next state: amplitude scaling; the output holds when no sample arrives
  always_comb begin
    vld_p3_d = vld_p2_q;
    dac_p3_d = dac_p3_q;
    if (vld_p2_q) begin
      dac_p3_d = scale_code(wave_p2_q, amp_p2_q);
    end
  end

  // ---- stage 3 boundary ----
  // Stage 3 state register: drives the DAC, parking at mid-scale in reset
  always_ff @(posedge clk_DDS or negedge Rst) begin
    if (!Rst) begin
      vld_p3_q <= 1'b0;
      dac_p3_q <= MID_CODE;
    end else begin
      vld_p3_q <= vld_p3_d;
      dac_p3_q <= dac_p3_d;
    end
  end

  assign Dac_Out   = dac_p3_q;
  assign Valid_Out = vld_p3_q;

endmodule

// File: tb/tb_dds_wave_shaper.sv
// Testbench for dds_wave_shaper. Expected codes are queued when a sample is
// driven and compared when the DUT raises Valid_Out.
`timescale 1ns/1ps
module tb_dds_wave_shaper;

  localparam real PI = 3.14159265358979323846;

  logic       clk_DDS;
  logic       Rst;
  logic       Valid_In;
  logic [7:0] Addr_In;
  logic [1:0] Wave_Sel;
  logic [7:0] Amp;
  logic [7:0] Dac_Out;
  logic       Valid_Out;

  int tests;
  int fails;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  dds_wave_shaper #(.MID_CODE(8'd128)) dut (
    .clk_DDS  (clk_DDS),
    .Rst      (Rst),
    .Valid_In (Valid_In),
    .Addr_In  (Addr_In),
    .Wave_Sel (Wave_Sel),
    .Amp      (Amp),
    .Dac_Out  (Dac_Out),
    .Valid_Out(Valid_Out)
  );

  initial clk_DDS = 1'b0;
  always #5 clk_DDS = ~clk_DDS;

  // Collect every output sample, away from the rising edge
  always @(negedge clk_DDS) begin
    if (Rst === 1'b1 && Valid_Out === 1'b1) obs_q.push_back(Dac_Out);
  end

  // Reference model, written from the waveform equations
  function automatic logic [7:0] golden(input int a, input int sel, input int amp);
    int q, i, k, m, w, s, p;
    q = a >> 6;
    i = a & 63;
    k = ((q & 1) != 0) ? (63 - i) : i;
    m = $rtoi(127.5 * $sin(2.0 * PI * (real'(k) + 0.5) / 256.0) + 0.5);
    case (sel)
      0:       w = ((q & 2) != 0) ? (127 - m) : (128 + m);
      1:       w = ((a & 128) != 0) ? 0 : 255;
      2:       w = ((a & 128) != 0) ? (255 - 2 * (a & 127)) : (2 * (a & 127));
      default: w = a;
    endcase
    s = w - 128;
    p = s * (amp + 1);
    return 8'(128 + (p >>> 8));
  endfunction

  task automatic send(input logic [7:0] a, input logic [1:0] sel,
                      input logic [7:0] amp, input logic [7:0] expv, input bit push);
    @(posedge clk_DDS);
    #1;
    Valid_In = 1'b1;
    Addr_In  = a;
    Wave_Sel = sel;
    Amp      = amp;
    if (push) exp_q.push_back(expv);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk_DDS);
      #1;
      Valid_In = 1'b0;
    end
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (obs_q.size() >= exp_q.size()) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk_DDS);
      #1;
    end
    ok = (obs_q.size() >= exp_q.size());
  endtask

  task automatic test_reset();
    bit ok;
    logic [7:0] e, o;
    int n;
    Rst = 1'b1; Valid_In = 1'b0; Addr_In = 8'd0; Wave_Sel = 2'd0; Amp = 8'd255;
    #2 Rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk_DDS);
      #1;
      Valid_In = ~Valid_In;
      Addr_In  = 8'($urandom_range(0, 255));
      @(negedge clk_DDS);
      tests++;
      if (Dac_Out !== 8'd128 || Valid_Out !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold[%0d] dac=%0d vld=%b required dac=128 vld=0", c, Dac_Out, Valid_Out);
      end
    end
    Valid_In = 1'b0;
    @(negedge clk_DDS);
    Rst = 1'b1;
    idle(2);
    send(8'd200, 2'd3, 8'd255, 8'd200, 1'b1);
    @(posedge clk_DDS);
    #1;
    Valid_In = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_DDS);
      tests++;
      if (Valid_Out !== (c == 2)) begin
        fails++;
        $display("FAIL latency edge+%0d vld=%b required %b", c + 1, Valid_Out, (c == 2));
      end
    end
    wait_out(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL reset_drain timeout got %0d samples required %0d", obs_q.size(), exp_q.size()); end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL reset_first[%0d] got %0d required %0d", n, o, e); end
      n++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_sine();
    bit ok;
    logic [7:0] e, o;
    int n;
    send(8'd0,   2'd0, 8'd255, 8'd130, 1'b1);
    send(8'd64,  2'd0, 8'd255, 8'd255, 1'b1);
    send(8'd128, 2'd0, 8'd255, 8'd125, 1'b1);
    send(8'd192, 2'd0, 8'd255, 8'd0,   1'b1);
    idle(1);
    wait_out(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL sine_drain timeout got %0d samples required %0d", obs_q.size(), exp_q.size()); end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL sine[%0d] got %0d required %0d", n, o, e); end
      n++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_other_waves();
    bit ok;
    logic [7:0] e, o;
    int n;
    send(8'd127, 2'd1, 8'd255, 8'd255, 1'b1);
    send(8'd128, 2'd1, 8'd255, 8'd0,   1'b1);
    send(8'd0,   2'd2, 8'd255, 8'd0,   1'b1);
    send(8'd127, 2'd2, 8'd255, 8'd254, 1'b1);
    send(8'd128, 2'd2, 8'd255, 8'd255, 1'b1);
    send(8'd255, 2'd2, 8'd255, 8'd1,   1'b1);
    send(8'd200, 2'd3, 8'd255, 8'd200, 1'b1);
    send(8'd255, 2'd3, 8'd255, 8'd255, 1'b1);
    send(8'd0,   2'd3, 8'd255, 8'd0,   1'b1);
    idle(1);
    wait_out(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL waves_drain timeout got %0d samples required %0d", obs_q.size(), exp_q.size()); end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL waves[%0d] got %0d required %0d", n, o, e); end
      n++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_scaling();
    bit ok;
    logic [7:0] e, o;
    int n;
    send(8'd0,   2'd1, 8'd127, 8'd191, 1'b1);
    send(8'd128, 2'd1, 8'd127, 8'd64,  1'b1);
    send(8'd0,   2'd1, 8'd0,   8'd128, 1'b1);
    send(8'd128, 2'd1, 8'd0,   8'd127, 1'b1);
    idle(1);
    wait_out(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL scale_drain timeout got %0d samples required %0d", obs_q.size(), exp_q.size()); end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL scale[%0d] got %0d required %0d", n, o, e); end
      n++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_midstream_hold();
    bit ok;
    logic [7:0] e, o;
    int n;
    send(8'd10, 2'd3, 8'd255, 8'd10,  1'b1);
    send(8'd11, 2'd3, 8'd255, 8'd11,  1'b1);
    send(8'd12, 2'd1, 8'd255, 8'd255, 1'b1);
    idle(1);
    wait_out(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL switch_drain timeout got %0d samples required %0d", obs_q.size(), exp_q.size()); end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL switch[%0d] got %0d required %0d", n, o, e); end
      n++;
    end
    exp_q.delete(); obs_q.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_DDS);
      tests++;
      if (Dac_Out !== 8'd255 || Valid_Out !== 1'b0) begin
        fails++;
        $display("FAIL hold[%0d] dac=%0d vld=%b required dac=255 vld=0", c, Dac_Out, Valid_Out);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] e, o;
    int n;
    send(8'd50, 2'd3, 8'd255, 8'd50, 1'b1);
    idle(1);
    wait_out(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL midrst_pre timeout got %0d samples required %0d", obs_q.size(), exp_q.size()); end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL midrst_pre[%0d] got %0d required %0d", n, o, e); end
      n++;
    end
    exp_q.delete(); obs_q.delete();
    send(8'd0, 2'd1, 8'd255, 8'd0, 1'b0);
    send(8'd1, 2'd1, 8'd255, 8'd0, 1'b0);
    @(posedge clk_DDS);
    #1;
    Valid_In = 1'b0;
    #2;
    Rst = 1'b0;
    #1;
    tests++;
    if (Dac_Out !== 8'd128 || Valid_Out !== 1'b0) begin
      fails++;
      $display("FAIL midrst_async dac=%0d vld=%b required dac=128 vld=0", Dac_Out, Valid_Out);
    end
    @(negedge clk_DDS);
    @(negedge clk_DDS);
    Rst = 1'b1;
    idle(6);
    @(negedge clk_DDS);
    tests++;
    if (obs_q.size() != 0 || Dac_Out !== 8'd128) begin
      fails++;
      $display("FAIL midrst_flush pulses=%0d dac=%0d required pulses=0 dac=128", obs_q.size(), Dac_Out);
    end
    obs_q.delete();
  endtask

  task automatic test_sine_sweep();
    bit ok;
    logic [7:0] e, o;
    int n;
    for (int a = 0; a < 256; a++) begin
      send(8'(a), 2'd0, 8'd255, golden(a, 0, 255), 1'b1);
    end
    idle(1);
    wait_out(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL sweep_drain timeout got %0d samples required %0d", obs_q.size(), exp_q.size()); end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL sweep[%0d] got %0d required %0d", n, o, e); end
      n++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] e, o;
    int n, a, s, m;
    for (int c = 0; c < 80; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        a = int'($urandom_range(0, 255));
        s = int'($urandom_range(0, 3));
        m = int'($urandom_range(0, 255));
        send(8'(a), 2'(s), 8'(m), golden(a, s, m), 1'b1);
      end
    end
    idle(1);
    wait_out(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL random_drain timeout got %0d samples required %0d", obs_q.size(), exp_q.size()); end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL random[%0d] got %0d required %0d", n, o, e); end
      n++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_sine();
    test_other_waves();
    test_scaling();
    test_midstream_hold();
    test_reset_mid();
    test_sine_sweep();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "time limit");
  end

endmodule
